// File: rtl/jk_ff.sv
// rtl/jk_ff.sv - bank of independent JK flip-flops with synchronous reset
//
// Purpose:
//   WIDTH independent JK flip-flops that share one clock and one synchronous
//   reset. Each bit holds (00), resets (01), sets (10) or toggles (11)
//   according to {j[i],k[i]}, sampled on the rising edge of clk.
//
// Optional feature:
//   JK_FF_CE_EN - when defined, adds a clock-enable input ce. With ce=0 the
//   register holds regardless of j/k. Reset still overrides ce.
//
// Ports:
//   clk  in   1      clock, rising edge active
//   rst  in   1      synchronous reset, active-high, loads RESET_VAL
//   ce   in   1      clock enable (only with JK_FF_CE_EN)
//   j    in   WIDTH  per-bit set control
//   k    in   WIDTH  per-bit reset control
//   q    out  WIDTH  registered state
//   qn   out  WIDTH  complement of q, derived combinationally from q
module jk_ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
`ifdef JK_FF_CE_EN
  input  logic             ce,
`endif
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  logic en;

`ifdef JK_FF_CE_EN
  assign en = ce;
`else
  assign en = 1'b1;
`endif

  // Characteristic equation: a bit goes high when set from 0 (j & ~q) or
  // stays high unless reset (~k & q); j=k=1 therefore inverts the bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= (j & ~q) | (~k & q);
    end
  end

  // qn is never registered on its own, so it can never disagree with q.
  assign qn = ~q;

endmodule

// File: tb/tb_jk_ff.sv
// tb/tb_jk_ff.sv - self-checking bench for jk_ff (1-bit and 4-bit instances)
module tb_jk_ff;

  logic       clk = 1'b0;
  logic       ce  = 1'b1;

  logic       r1, j1, k1;
  logic       q1, qn1;

  logic       r4;
  logic [3:0] j4, k4;
  logic [3:0] q4, qn4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jk_ff #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
    .clk (clk),
    .rst (r1),
`ifdef JK_FF_CE_EN
    .ce  (ce),
`endif
    .j   (j1),
    .k   (k1),
    .q   (q1),
    .qn  (qn1)
  );

  jk_ff #(.WIDTH(4), .RESET_VAL(4'b1010)) u_dut4 (
    .clk (clk),
    .rst (r4),
`ifdef JK_FF_CE_EN
    .ce  (ce),
`endif
    .j   (j4),
    .k   (k4),
    .q   (q4),
    .qn  (qn4)
  );

  typedef struct {
    logic  rst;
    logic  j;
    logic  k;
    logic  exp_q;
    string name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Advance one rising edge, then wait half a cycle so outputs are sampled
  // well away from the active edge.
  task automatic tick();
    @(posedge clk);
    #5;
  endtask

  // Reference model: spelled out as the mode table, one bit at a time.
  function automatic logic [3:0] model_next(input logic [3:0] cur, input logic [3:0] jv,
                                            input logic [3:0] kv, input int w,
                                            input logic [3:0] rv, input logic rs,
                                            input logic en);
    logic [3:0] nxt;
    nxt = cur;
    if (rs) return rv;
    if (!en) return cur;
    for (int i = 0; i < w; i++) begin
      case ({jv[i], kv[i]})
        2'b00:   nxt[i] = cur[i];
        2'b01:   nxt[i] = 1'b0;
        2'b10:   nxt[i] = 1'b1;
        default: nxt[i] = (cur[i] == 1'b1) ? 1'b0 : 1'b1;
      endcase
    end
    return nxt;
  endfunction

  task automatic add(input logic rs, input logic jv, input logic kv, input logic e,
                     input string n);
    vec_t v;
    v.rst = rs; v.j = jv; v.k = kv; v.exp_q = e; v.name = n;
    vecs.push_back(v);
  endtask

  logic       m1;
  logic [3:0] m4;

  initial begin
    r1 = 1'b1; j1 = 1'b0; k1 = 1'b0;
    r4 = 1'b1; j4 = 4'b0; k4 = 4'b0;
    ce = 1'b1;

    add(1, 0, 0, 0, "reset_00");
    add(1, 1, 1, 0, "reset_priority_11");
    add(0, 0, 0, 0, "sweep_hold");
    add(0, 0, 1, 0, "sweep_reset");
    add(0, 1, 0, 1, "sweep_set");
    add(0, 1, 1, 0, "sweep_toggle");
    add(0, 1, 0, 1, "set_again");
    add(0, 0, 0, 1, "hold_1");
    add(0, 0, 0, 1, "hold_2");
    add(0, 0, 0, 1, "hold_3");
    add(0, 0, 1, 0, "clear");
    add(0, 1, 1, 1, "toggle_1");
    add(0, 1, 1, 0, "toggle_2");
    add(0, 1, 1, 1, "toggle_3");
    add(0, 1, 1, 0, "toggle_4");
    add(0, 1, 1, 1, "toggle_5");
    add(1, 1, 1, 0, "reset_mid_toggle");
    add(0, 1, 1, 1, "release_into_toggle");

    foreach (vecs[i]) begin
      r1 = vecs[i].rst; j1 = vecs[i].j; k1 = vecs[i].k;
      tick();
      chk({vecs[i].name, "_q"},  {3'b0, q1},  {3'b0, vecs[i].exp_q});
      chk({vecs[i].name, "_qn"}, {3'b0, qn1}, {3'b0, ~vecs[i].exp_q});
    end

    // q1 is 1 here; a reset pulse that does not span a rising edge is ignored.
    r1 = 1'b0; j1 = 1'b0; k1 = 1'b0;
    #1 r1 = 1'b1;
    #2 r1 = 1'b0;
    tick();
    chk("rst_between_edges", {3'b0, q1}, 4'b0001);

    // 4-bit instance: reset value, then mixed modes in one cycle.
    r4 = 1'b1; j4 = 4'b0; k4 = 4'b0;
    tick();
    chk("w4_reset_q",  q4,  4'b1010);
    chk("w4_reset_qn", qn4, 4'b0101);
    r4 = 1'b0; j4 = 4'b0011; k4 = 4'b0101;
    tick();
    chk("w4_mixed_q",  q4,  4'b1011);
    chk("w4_mixed_qn", qn4, 4'b0100);

`ifdef JK_FF_CE_EN
    ce = 1'b1; r1 = 1'b0; j1 = 1'b1; k1 = 1'b0;
    tick();
    chk("ce_set", {3'b0, q1}, 4'b0001);
    ce = 1'b0; j1 = 1'b0; k1 = 1'b1;
    tick();
    chk("ce_off_hold", {3'b0, q1}, 4'b0001);
    ce = 1'b1;
    tick();
    chk("ce_on_reset", {3'b0, q1}, 4'b0000);
    j1 = 1'b1; k1 = 1'b0;
    tick();
    chk("ce_set_again", {3'b0, q1}, 4'b0001);
    ce = 1'b0; r1 = 1'b1; j1 = 1'b0; k1 = 1'b0;
    tick();
    chk("ce_off_rst_wins", {3'b0, q1}, 4'b0000);
    ce = 1'b1;
`endif

    // Randomized run against the model; first cycle forces reset so the
    // model starts from a known state.
    m1 = 1'b0;
    m4 = 4'b0;
    for (int n = 0; n < 300; n++) begin
      r1 = (n == 0) || ($urandom_range(0, 15) == 0);
      r4 = (n == 0) || ($urandom_range(0, 15) == 0);
      j1 = 1'($urandom);
      k1 = 1'($urandom);
      j4 = 4'($urandom);
      k4 = 4'($urandom);
`ifdef JK_FF_CE_EN
      ce = 1'($urandom);
`endif
      m1 = model_next({3'b0, m1}, {3'b0, j1}, {3'b0, k1}, 1, 4'b0000, r1, ce) != 4'b0;
      m4 = model_next(m4, j4, k4, 4, 4'b1010, r4, ce);
      tick();
      chk("rand_w1_q",  {3'b0, q1},  {3'b0, m1});
      chk("rand_w1_qn", {3'b0, qn1}, {3'b0, ~m1});
      chk("rand_w4_q",  q4,  m4);
      chk("rand_w4_qn", qn4, ~m4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
